// File: rtl/user_sobel_fetch_sched.sv
// user_sobel_fetch_sched: walks interior pixel centres, fetches each neighbourhood over OBI, hands windows to the Sobel datapath.
// Define USER_SOBEL_FETCH_CENTER_EN to also fetch the centre pixel (9-pixel windows instead of 8).
module user_sobel_fetch_sched #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int DimWidth = 10,
`ifdef USER_SOBEL_FETCH_CENTER_EN
  localparam int NPIX = 9
`else
  localparam int NPIX = 8
`endif
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [AddrWidth-1:0]   base_addr_i,
  input  logic [DimWidth-1:0]    img_w_i,
  input  logic [DimWidth-1:0]    img_h_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   obi_req_o,
  input  logic                   obi_gnt_i,
  output logic [AddrWidth-1:0]   obi_addr_o,
  output logic                   obi_we_o,
  output logic [3:0]             obi_be_o,
  output logic [DataWidth-1:0]   obi_wdata_o,
  input  logic                   obi_rvalid_i,
  input  logic [DataWidth-1:0]   obi_rdata_i,
  input  logic                   obi_err_i,
  output logic                   win_valid_o,
  input  logic                   win_ready_i,
  output logic [8*NPIX-1:0]      win_pix_o,
  output logic [DimWidth-1:0]    win_x_o,
  output logic [DimWidth-1:0]    win_y_o
);
  typedef enum logic [2:0] {IDLE, ADDR, RESP, OUT, DONE} state_t;
  state_t state;
  logic [AddrWidth-1:0] base;
  logic [DimWidth-1:0] w, h, x, y, nx, ny;
  logic [3:0] k;
  logic [NPIX-1:0][7:0] pix;
  logic xe, last, unused_rdata;
  assign obi_we_o = 1'b0;
  assign obi_be_o = 4'hF;
  assign obi_wdata_o = '0;
  assign win_pix_o = pix;
  assign unused_rdata = ^obi_rdata_i[DataWidth-1:8];
  // Slot kk maps to raster position p in the 3x3 neighbourhood; without centre fetch p skips 4.
  function automatic logic [AddrWidth-1:0] addr_f(input logic [AddrWidth-1:0] b,
      input logic [DimWidth-1:0] wd, cx, cy, input logic [3:0] kk);
    logic [3:0] p;
    logic [DimWidth-1:0] r, c;
    logic [2*DimWidth-1:0] off;
    p = (NPIX == 9 || kk < 4'd4) ? kk : kk + 4'd1;
    r = cy + DimWidth'(p / 4'd3) - DimWidth'(1);
    c = cx + DimWidth'(p % 4'd3) - DimWidth'(1);
    off = {{DimWidth{1'b0}}, r} * {{DimWidth{1'b0}}, wd} + {{DimWidth{1'b0}}, c};
    return b + AddrWidth'({off, 2'b00});
  endfunction
  always_comb begin
    xe = x == w - DimWidth'(2);
    last = xe && y == h - DimWidth'(2);
    nx = xe ? DimWidth'(1) : x + DimWidth'(1);
    ny = xe ? y + DimWidth'(1) : y;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      base <= '0;
      w <= '0;
      h <= '0;
      x <= '0;
      y <= '0;
      k <= '0;
      pix <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      obi_req_o <= 1'b0;
      obi_addr_o <= '0;
      win_valid_o <= 1'b0;
      win_x_o <= '0;
      win_y_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          base <= base_addr_i;
          w <= img_w_i;
          h <= img_h_i;
          err_o <= 1'b0;
          x <= DimWidth'(1);
          y <= DimWidth'(1);
          k <= '0;
          if (img_w_i < DimWidth'(3) || img_h_i < DimWidth'(3)) begin
            done_o <= 1'b1;
            state <= DONE;
          end else begin
            busy_o <= 1'b1;
            obi_req_o <= 1'b1;
            obi_addr_o <= addr_f(base_addr_i, img_w_i, DimWidth'(1), DimWidth'(1), 4'd0);
            state <= ADDR;
          end
        end
        ADDR: if (obi_gnt_i) begin
          obi_req_o <= 1'b0;
          state <= RESP;
        end
        RESP: if (obi_rvalid_i) begin
          if (obi_err_i) begin
            err_o <= 1'b1;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state <= DONE;
          end else begin
            pix[k[$clog2(NPIX)-1:0]] <= obi_rdata_i[7:0];
            if (k == 4'(NPIX - 1)) begin
              win_valid_o <= 1'b1;
              win_x_o <= x;
              win_y_o <= y;
              state <= OUT;
            end else begin
              k <= k + 4'd1;
              obi_req_o <= 1'b1;
              obi_addr_o <= addr_f(base, w, x, y, k + 4'd1);
              state <= ADDR;
            end
          end
        end
        OUT: if (win_ready_i) begin
          win_valid_o <= 1'b0;
          if (last) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state <= DONE;
          end else begin
            x <= nx;
            y <= ny;
            k <= '0;
            obi_req_o <= 1'b1;
            obi_addr_o <= addr_f(base, w, nx, ny, 4'd0);
            state <= ADDR;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
